uart_tx: RTL
============

# uart_tx

Serial UART transmitter that consumes the divided baud clock produced by `clk_div` (e.g. 50 MHz in, 9600 out) and shifts out one frame per accepted byte, one bit per baud period. Sits directly downstream of the divider: `clk_div.new_clk` feeds `baud_clk`, and the system clock feeds both blocks. Bytes are offered on a valid/ready handshake; `tx` drives the pad.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: stop bits per frame, legal 1 or 2.

Ports:
- `clk` input, 1: system clock, same clock as `clk_div`.
- `rst` input, 1: one clock; reset is asynchronous and active-high.
- `baud_clk` input, 1: divider output (`new_clk`); frequency ≤ clk/4.
- `tx_data` input, DATA_BITS: byte to send, LSB first.
- `tx_valid` input, 1: `tx_data` is valid.
- `tx_ready` output, 1: block accepts `tx_data` this cycle.
- `tx` output, 1: serial line, idle high, registered.
- `busy` output, 1: high from acceptance until the frame's final stop bit ends.

## Operation
- Baud edge: `baud_clk` passes through 2 sync flops plus 1 history flop; `tick` = sync_out & ~history (one clk cycle wide). All three flops reset to 1, so no spurious tick on reset release whatever the level of `baud_clk`.
- Transfer on any cycle where `tx_valid && tx_ready`; `tx_data` and the computed parity are latched into the shift register that cycle.
- States, all transitions on `tick` unless stated:
  - IDLE: `tx`=1, `tx_ready`=1. On transfer (no tick needed) -> LOAD.
  - LOAD: `tx`=1. On tick -> START, `tx`<=0.
  - START: on tick -> DATA, `tx`<=bit0.
  - DATA: on each tick shift; after DATA_BITS bits -> PARITY (`tx`<=parity) if PARITY≠0, else -> STOP (`tx`<=1).
  - PARITY: on tick -> STOP, `tx`<=1.
  - STOP: counts STOP_BITS ticks. On the tick ending the last stop bit: -> IDLE, or -> START with `tx`<=0 if a transfer was accepted during the last stop bit.
- `tx_ready` is 1 in IDLE and during the last stop bit when no byte is already pending; 0 elsewhere. This gives gapless back-to-back frames.
- Parity: even = XOR of data bits; odd = its inverse.
- Frame = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS baud periods.
- `tx_valid` with `tx_ready`=0: ignored; `tx_data` is not sampled.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, state IDLE, counters 0.
- `tick` is high in the clk cycle 2 clk edges after `baud_clk` rises. `tx` changes on the clk edge that ends that tick cycle, i.e. 3 clk edges after the `baud_clk` rising edge.
- Each bit lasts exactly one `baud_clk` period (±1 clk of jitter from synchronization).
- First start bit begins on the first tick strictly after the transfer cycle. A tick in the same cycle as the transfer is not used for that frame.
- `busy` rises on the edge after the transfer and falls on the edge that enters IDLE.
- Async reset mid-frame: `tx` returns to 1 immediately and any pending byte is discarded.
- `baud_clk` stopped: the FSM holds its state indefinitely; no timeout.

## Structure
- Package `uart_pkg`: state enum (IDLE, LOAD, START, DATA, PARITY, STOP), parity constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2), shared with the future `uart_rx`.
- Sub-module `baud_edge_sync`: 3-flop synchronizer plus rising-edge detector producing `tick`; reused by `uart_rx`.
- Bit counter width: $clog2(DATA_BITS+1). Stop counter: 1 bit.

## Test plan
- 8N1, `clk_div` with IN_FREQ=1000, OUT_FREQ=100 (10 clk per bit), send 0xA5 -> `tx` = 0,1,0,1,0,0,1,0,1,1, each held 10±1 clk; `busy` spans 10 bit periods.
- PARITY=1 send 0x03 -> parity bit 0; PARITY=2 send 0x03 -> parity bit 1; STOP_BITS=2 -> line high for 2 bit periods before IDLE.
- Back-to-back: hold `tx_valid` high with 0x55 then 0xAA -> second start bit begins on the tick ending the first stop bit, with no idle bit in between; `tx_ready` pulses only in IDLE and the last stop bit.
- Reset asserted in the middle of DATA of 0xFF -> `tx`=1 asynchronously, `busy`=0, `tx_ready`=1; next byte 0x81 is sent correctly.
- `baud_clk` held high through reset release -> no tick and `tx` stays 1; the first frame starts only after a real rising edge.
- `tx_valid` pulsed while busy with 0x11 -> byte is not sent and the output frame is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and the future receiver.
// Parity modes are plain ints so they can be used directly as parameter values.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Callers zero-extend narrower words; the extra zeros do not change the XOR.
   function automatic logic calc_parity(input logic [8:0] data, input int mode);
      return (mode == PAR_ODD) ? ~(^data) : ^data;
   endfunction

endpackage

// File: rtl/baud_edge_sync.sv
// Synchronizes the divided baud clock into the system domain and emits a one-cycle
// tick on each rising edge. Every flop resets high so reset release never fakes an edge.
module baud_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic baud_clk,
   output logic tick
);

   // [0],[1] are the synchronizer stages, [2] holds the previous synchronized level.
   logic [2:0] sync_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_pipe <= '1;
      else     sync_pipe <= {sync_pipe[1:0], baud_clk};
   end

   assign tick = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one frame per accepted word, one bit per baud tick, LSB first.
// A word accepted during the last stop bit starts on the next tick with no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_clk,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int BCW = $clog2(DATA_BITS + 1);

   uart_state_e      state, state_nxt;
   logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
   logic             stop_cnt, stop_cnt_nxt;
   logic [DATA_BITS:0] shreg, shreg_nxt;
   logic             pending, pending_nxt;
   logic             tx_nxt, busy_nxt;
   logic             tick, xfer, last_stop, par_bit;

   baud_edge_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .baud_clk (baud_clk),
      .tick     (tick)
   );

   assign last_stop = (state == S_STOP) && (stop_cnt == 1'(STOP_BITS - 1));
   assign tx_ready  = (state == S_IDLE) || (last_stop && !pending);
   assign xfer      = tx_valid && tx_ready;
   assign par_bit   = (PARITY != PAR_NONE) ? calc_parity(9'(tx_data), PARITY) : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         pending  <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         stop_cnt <= stop_cnt_nxt;
         shreg    <= shreg_nxt;
         pending  <= pending_nxt;
         tx       <= tx_nxt;
         busy     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      shreg_nxt    = shreg;
      pending_nxt  = pending;
      tx_nxt       = tx;
      busy_nxt     = busy;

      // The shift register is idle in IDLE and STOP, the only states that accept.
      if (xfer) begin
         shreg_nxt = {par_bit, tx_data};
         busy_nxt  = 1'b1;
      end

      case (state)
         S_IDLE: begin
            tx_nxt = 1'b1;
            if (xfer) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (tick) begin
               state_nxt = S_START;
               tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (tick) begin
               state_nxt   = S_DATA;
               tx_nxt      = shreg[0];
               shreg_nxt   = shreg >> 1;
               bit_cnt_nxt = BCW'(1);
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_cnt == BCW'(DATA_BITS)) begin
                  // After DATA_BITS shifts the parity bit sits at shreg[0].
                  if (PARITY != PAR_NONE) begin
                     state_nxt = S_PARITY;
                     tx_nxt    = shreg[0];
                  end else begin
                     state_nxt    = S_STOP;
                     tx_nxt       = 1'b1;
                     stop_cnt_nxt = 1'b0;
                  end
               end else begin
                  tx_nxt      = shreg[0];
                  shreg_nxt   = shreg >> 1;
                  bit_cnt_nxt = bit_cnt + BCW'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               state_nxt    = S_STOP;
               tx_nxt       = 1'b1;
               stop_cnt_nxt = 1'b0;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (last_stop) begin
                  if (pending) begin
                     state_nxt   = S_START;
                     tx_nxt      = 1'b0;
                     pending_nxt = 1'b0;
                  end else if (xfer) begin
                     // A tick coinciding with acceptance is not used for the new frame.
                     state_nxt = S_LOAD;
                  end else begin
                     state_nxt = S_IDLE;
                     busy_nxt  = 1'b0;
                  end
               end else begin
                  stop_cnt_nxt = 1'b1;
               end
            end else if (xfer) begin
               pending_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule
